alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised successor to the combinational integer ALU. Adds valid/ready handshakes on operand and result sides, a registered result, and an iterative shift-add integer multiply on a 5-bit opcode. Sits between the operand-read stage and writeback. A handshake stall propagates upstream while a multiply is iterating or the result is not drained. Floating-point opcodes stay reserved and are flagged, not computed.

## Interface
- `WIDTH`, 16, data word width in bits (≥2).
- `CW`, derived `$clog2(WIDTH+1)`, iteration counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  operand/op presented.
- `in_ready`  out  1  block can accept; transfer when `in_valid && in_ready` at an edge.
- `op`  in  5  opcode.
- `in1`, `in2`  in  WIDTH  operands.
- `out_valid`  out  1  result register holds an undelivered result.
- `out_ready`  in  1  consumer accepts; drain when `out_valid && out_ready` at an edge.
- `result`  out  WIDTH  registered result.
- `carry`  out  1  carry-out of `add`; 0 for all other ops.
- `illegal`  out  1  op was reserved or unknown.

## Operation
- Opcodes: add 0x00, and 0x04, or 0x05, xor 0x06, any 0x07, dup 0x08, shr 0x09, mul 0x10.
- Reserved float opcodes: invf 0x01, addf 0x02, mulf 0x03, f2i 0x0A, i2f 0x0B.
- Single-cycle ops:
  - add: `{carry,result} = in1 + in2`, result wraps mod 2^WIDTH.
  - and, or, xor: bitwise.
  - any: `result = {0…, |in1}`.
  - dup: `result = in1`.
  - shr: logical `in1 >> 1`, MSB 0.
- mul: low WIDTH bits of the unsigned product `in1*in2`; carry 0.
- Reserved/unknown op: `result = in1`, `illegal = 1`, single-cycle. For every other op, `illegal = 0`.
- FSM states:
  - IDLE: accepts when `in_ready`.
  - MUL: iterating.
- IDLE → MUL on accepting mul. MUL → IDLE when the counter reaches WIDTH, writing the result register.
- Multiply iteration, once per cycle in MUL:
  - if `mplier[0]`, `acc += mcand`;
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - Fixed WIDTH iterations; no early exit.
- Result register holds `result`, `carry` and `illegal`. It stays stable while `out_valid && !out_ready`.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`. Drain and accept in the same edge is legal and gives full throughput.
- Mul acceptance requires the same `in_ready` condition. Any previous result drains before or at acceptance, so the register is free when MUL completes.

## Timing
- Reset values:
  - state IDLE.
  - `out_valid` 0; `result`, `carry`, `illegal` 0.
  - `acc`, `mcand`, `mplier`, `cnt` 0.
  - `in_ready` 1 after reset deasserts.
- Single-cycle op accepted at edge k: `out_valid` = 1 and result visible after edge k (latency 1).
- mul accepted at edge k: iterations on edges k+1…k+WIDTH. Result and `out_valid` appear after edge k+WIDTH. `in_ready` = 0 from after edge k until after edge k+WIDTH.
- Back-to-back single-cycle ops with `out_ready` high: one result per cycle.
- `out_ready` low while `out_valid`: `in_ready` drops combinationally; result held.
- Inputs are sampled only on the accepting edge. Changing `in1`/`in2`/`op` during MUL has no effect.
- Reset asserted mid-multiply or mid-stall: immediate return to reset values; partial product discarded; no result emitted.

## Structure
- Package `alu_pkg`:
  - opcode localparams (all 13 codes);
  - FSM state encoding;
  - helper function `is_reserved(op)`.
- Sub-module `alu_mul_iter`, holding `acc`/`mcand`/`mplier`/`cnt`:
  - ports `clk`, `reset`, `start`, `a`, `b`, `done`, `p`;
  - `done` is a one-cycle pulse on the final iteration edge.
- Top level holds the FSM, the single-cycle datapath and the result register.

## Test plan
- Reset: assert `reset` mid-mul (WIDTH=16, 5 cycles in) → all outputs 0, `in_ready` = 1 one cycle after release, no spurious `out_valid`.
- add 0xFFFF + 0x0001 → result 0x0000, carry 1; add 0x1234 + 0x0001 → 0x1235, carry 0.
- Streaming, `out_ready` held 1: and, or, xor, any, dup, shr on 0xF0F0 / 0x0FF0.
  - Expected: 0x00F0, 0xFFF0, 0xFF00, 0x0001, 0xF0F0, 0x7878, one per cycle.
  - any on 0x0000 → 0x0000.
- mul 0x0123 × 0x0010 → 0x1230 exactly 16 cycles after accept; mul 0xFFFF × 0xFFFF → 0x0001.
  - `in_ready` low throughout the iteration.
- Backpressure: `out_ready` = 0 for 3 cycles after a result → result/flags stable, `in_ready` = 0. Raising `out_ready` with `in_valid` set → drain and accept on the same edge.
- Reserved op 0x02 with in1 = 0xABCD → result 0xABCD, `illegal` 1, latency 1. The next legal op clears `illegal`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode classification for the multi-cycle ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_INVF = 5'h01;
    localparam logic [4:0] OP_ADDF = 5'h02;
    localparam logic [4:0] OP_MULF = 5'h03;
    localparam logic [4:0] OP_AND  = 5'h04;
    localparam logic [4:0] OP_OR   = 5'h05;
    localparam logic [4:0] OP_XOR  = 5'h06;
    localparam logic [4:0] OP_ANY  = 5'h07;
    localparam logic [4:0] OP_DUP  = 5'h08;
    localparam logic [4:0] OP_SHR  = 5'h09;
    localparam logic [4:0] OP_F2I  = 5'h0A;
    localparam logic [4:0] OP_I2F  = 5'h0B;
    localparam logic [4:0] OP_MUL  = 5'h10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // Float opcodes and any unassigned code are treated alike: flagged, not computed.
    function automatic logic is_reserved(input logic [4:0] op);
        case (op)
            OP_ADD, OP_AND, OP_OR, OP_XOR, OP_ANY,
            OP_DUP, OP_SHR, OP_MUL: is_reserved = 1'b0;
            default:                is_reserved = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: fixed WIDTH iterations after start, low WIDTH product bits.
module alu_mul_iter #(
    parameter int WIDTH = 16,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    logic             active_q, active_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        active_d = active_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        if (start) begin
            active_d = 1'b1;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // done is asserted during the cycle whose edge performs the last iteration
            if (cnt_q == CW'(WIDTH - 1)) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end
    end

    // Only meaningful while done is high: the accumulator value the final edge will store.
    assign p = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: handshaked operands, registered result, iterative multiply.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             illegal,
    output alu_state_e       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and the result register is held unchanged while out_valid && !out_ready.

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             drain;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;

    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_illegal;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid_q && out_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (in1),
        .b     (in2),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_comb begin
        sc_result  = in1;
        sc_carry   = 1'b0;
        sc_illegal = is_reserved(op);
        case (op)
            OP_ADD: {sc_carry, sc_result} = {1'b0, in1} + {1'b0, in2};
            OP_AND: sc_result = in1 & in2;
            OP_OR:  sc_result = in1 | in2;
            OP_XOR: sc_result = in1 ^ in2;
            OP_ANY: sc_result = {{(WIDTH-1){1'b0}}, |in1};
            OP_DUP: sc_result = in1;
            OP_SHR: sc_result = in1 >> 1;
            default: sc_result = in1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        illegal_d   = illegal_q;
        if (drain) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_MUL;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = sc_result;
                    carry_d     = sc_carry;
                    illegal_d   = sc_illegal;
                end
            end
            ST_MUL: begin
                // The register was freed at acceptance, so completion never overwrites a result.
                if (mul_done) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_p;
                    carry_d     = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: reset, single-cycle ops, multiply, backpressure, reserved ops.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         illegal;
    alu_state_e   dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset_outputs got v=%b c=%b i=%b r=%h want 0 0 0 0000",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_add;
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_ADD; in1 = 16'hFFFF; in2 = 16'h0001;
        @(posedge clk); #1;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b1, 1'b1, 1'b0, 16'h0000})
            $display("FAIL add_wrap got v=%b c=%b i=%b r=%h want 1 1 0 0000",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
        in1 = 16'h1234; in2 = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b1, 1'b0, 1'b0, 16'h1235})
            $display("FAIL add_plain got v=%b c=%b i=%b r=%h want 1 0 0 1235",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
    endtask

    task automatic test_stream;
        logic [4:0]   ops [7];
        logic [W-1:0] exp [7];
        ops = '{OP_AND, OP_OR, OP_XOR, OP_ANY, OP_DUP, OP_SHR, OP_ANY};
        exp = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0001, 16'hF0F0, 16'h7878, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; op = ops[i];
            in1 = (i == 6) ? 16'h0000 : 16'hF0F0;
            in2 = 16'h0FF0;
            #1;
            total_cnt++;
            if (in_ready !== 1'b1)
                $display("FAIL stream_ready[%0d] got in_ready=%b want 1", i, in_ready);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if ({out_valid, illegal, result} !== {1'b1, 1'b0, exp[i]})
                $display("FAIL stream_result[%0d] got v=%b i=%b r=%h want 1 0 %h",
                         i, out_valid, illegal, result, exp[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mul;
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_MUL; in1 = 16'h0123; in2 = 16'h0010;
        @(posedge clk); #1;
        // Keep offering a different op; it must neither be accepted nor disturb the multiply.
        op = OP_ADD; in1 = 16'hFFFF; in2 = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if ({in_ready, out_valid, dbg_state} !== {1'b0, 1'b0, ST_MUL})
                $display("FAIL mul_busy[%0d] got in_ready=%b out_valid=%b state=%b want 0 0 1",
                         i, in_ready, out_valid, dbg_state);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, carry, illegal, result, in_ready} !== {1'b1, 1'b0, 1'b0, 16'h1230, 1'b1})
            $display("FAIL mul_small got v=%b c=%b i=%b r=%h rdy=%b want 1 0 0 1230 1",
                     out_valid, carry, illegal, result, in_ready);
        else pass_cnt++;

        in_valid = 1'b1; op = OP_MUL; in1 = 16'hFFFF; in2 = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b1, 1'b0, 1'b0, 16'h0001})
            $display("FAIL mul_max got v=%b c=%b i=%b r=%h want 1 0 0 0001",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_ADD; in1 = 16'hFFFF; in2 = 16'h0002;
        @(posedge clk); #1;
        out_ready = 1'b0;
        op = OP_XOR; in1 = 16'h0005; in2 = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if ({in_ready, out_valid, carry, illegal, result} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0001})
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b c=%b i=%b r=%h want 0 1 1 0 0001",
                         i, in_ready, out_valid, carry, illegal, result);
            else pass_cnt++;
            if (i < 3) @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL bp_release_ready got in_ready=%b want 1", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b1, 1'b0, 1'b0, 16'h0006})
            $display("FAIL bp_drain_accept got v=%b c=%b i=%b r=%h want 1 0 0 0006",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
    endtask

    task automatic test_reserved;
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_ADDF; in1 = 16'hABCD; in2 = 16'h1234;
        @(posedge clk); #1;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b1, 1'b0, 1'b1, 16'hABCD})
            $display("FAIL reserved_addf got v=%b c=%b i=%b r=%h want 1 0 1 abcd",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
        op = 5'h1F; in1 = 16'h0042;
        @(posedge clk); #1;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b1, 1'b0, 1'b1, 16'h0042})
            $display("FAIL unknown_op got v=%b c=%b i=%b r=%h want 1 0 1 0042",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
        op = OP_DUP; in1 = 16'h5555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, carry, illegal, result} !== {1'b1, 1'b0, 1'b0, 16'h5555})
            $display("FAIL illegal_clear got v=%b c=%b i=%b r=%h want 1 0 0 5555",
                     out_valid, carry, illegal, result);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL idle_drained got out_valid=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul;
        logic spurious;
        spurious = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_MUL; in1 = 16'h0123; in2 = 16'h0010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, carry, illegal, result, dbg_state} !== {1'b0, 1'b0, 1'b0, 16'h0000, ST_IDLE})
            $display("FAIL reset_mid_mul got v=%b c=%b i=%b r=%h state=%b want 0 0 0 0000 0",
                     out_valid, carry, illegal, result, dbg_state);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_mid_mul_ready got in_ready=%b want 1", in_ready);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) spurious = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (spurious !== 1'b0)
            $display("FAIL reset_no_spurious got out_valid seen=%b want 0", spurious);
        else pass_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 5'h00;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_stream();
        test_mul();
        test_backpressure();
        test_reserved();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
